// File: rtl/cla_adder_pipe.sv
// Pipelined block carry-lookahead adder with valid/ready streaming; one SW-bit slice per stage.
// Optional subtract mode is enabled by defining CLA_SUB_EN (adds the in_sub port).
module cla_adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int GROUP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef CLA_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int SW = WIDTH / STAGES;
    localparam int NG = SW / GROUP;

    logic [WIDTH-1:0] w_bEff;
    logic             w_cinEff;

`ifdef CLA_SUB_EN
    assign w_bEff   = in_b ^ {WIDTH{in_sub}};
    assign w_cinEff = in_cin ^ in_sub;
`else
    assign w_bEff   = in_b;
    assign w_cinEff = in_cin;
`endif

    // Every carry is a flat sum-of-products over g/p terms: bit carries inside a group and
    // group carries across the slice are both lookahead, never rippled.
    function automatic void claSlice(
        input  logic [SW-1:0] a,
        input  logic [SW-1:0] b,
        input  logic          cin,
        output logic [SW-1:0] sum,
        output logic          cout
    );
        logic [SW-1:0] g, p, c;
        logic [NG-1:0] gg, gp;
        logic [NG:0]   gc;
        logic          t;
        g = a & b;
        p = a ^ b;
        for (int j = 0; j < NG; j++) begin
            gp[j] = &p[j*GROUP +: GROUP];
            gg[j] = 1'b0;
            for (int i = 0; i < GROUP; i++) begin
                t = g[j*GROUP+i];
                for (int m = i + 1; m < GROUP; m++) t = t & p[j*GROUP+m];
                gg[j] = gg[j] | t;
            end
        end
        for (int j = 0; j <= NG; j++) begin
            t = cin;
            for (int m = 0; m < j; m++) t = t & gp[m];
            gc[j] = t;
            for (int i = 0; i < j; i++) begin
                t = gg[i];
                for (int m = i + 1; m < j; m++) t = t & gp[m];
                gc[j] = gc[j] | t;
            end
        end
        for (int j = 0; j < NG; j++) begin
            for (int i = 0; i < GROUP; i++) begin
                t = gc[j];
                for (int m = 0; m < i; m++) t = t & p[j*GROUP+m];
                c[j*GROUP+i] = t;
                for (int l = 0; l < i; l++) begin
                    t = g[j*GROUP+l];
                    for (int m = l + 1; m < i; m++) t = t & p[j*GROUP+m];
                    c[j*GROUP+i] = c[j*GROUP+i] | t;
                end
            end
        end
        sum  = p ^ c;
        cout = gc[NG];
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : gStage
        localparam int REM = WIDTH - k * SW;

        logic                 w_acc;
        logic                 w_inValid;
        logic                 w_cin;
        logic [REM-1:0]       w_a;
        logic [REM-1:0]       w_b;
        logic [SW-1:0]        w_sliceSum;
        logic                 w_sliceCout;
        logic [(k+1)*SW-1:0]  w_sumNext;
        logic [(k+1)*SW-1:0]  r_sum;
        logic                 r_valid;
        logic                 r_carry;

        // Stage 0 takes the raw beat; later stages take the operand bits still waiting to be added.
        if (k == 0) begin : gHead
            assign w_inValid = in_valid;
            assign w_a       = in_a;
            assign w_b       = w_bEff;
            assign w_cin     = w_cinEff;
            assign w_sumNext = w_sliceSum;
        end else begin : gBody
            assign w_inValid = gStage[k-1].r_valid;
            assign w_a       = gStage[k-1].gFwd.r_a;
            assign w_b       = gStage[k-1].gFwd.r_b;
            assign w_cin     = gStage[k-1].r_carry;
            assign w_sumNext = {w_sliceSum, gStage[k-1].r_sum};
        end

        if (k == STAGES - 1) begin : gAccLast
            assign w_acc = !r_valid || out_ready;
        end else begin : gAccMid
            assign w_acc = !r_valid || gStage[k+1].w_acc;
        end

        always_comb claSlice(w_a[SW-1:0], w_b[SW-1:0], w_cin, w_sliceSum, w_sliceCout);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_sum   <= '0;
                r_carry <= 1'b0;
            end else if (w_acc) begin
                r_valid <= w_inValid;
                if (w_inValid) begin
                    r_sum   <= w_sumNext;
                    r_carry <= w_sliceCout;
                end
            end
        end

        if (k < STAGES - 1) begin : gFwd
            logic [REM-SW-1:0] r_a;
            logic [REM-SW-1:0] r_b;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_acc && w_inValid) begin
                    r_a <= w_a[REM-1:SW];
                    r_b <= w_b[REM-1:SW];
                end
            end
        end else begin : gTail
            // Same-sign operands with a differently signed result is exactly carry-in(MSB) ^ carry-out(MSB).
            logic r_ovf;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_acc && w_inValid) begin
                    r_ovf <= (w_a[SW-1] == w_b[SW-1]) && (w_sliceSum[SW-1] != w_a[SW-1]);
                end
            end
        end
    end

    assign in_ready  = gStage[0].w_acc;
    assign out_valid = gStage[STAGES-1].r_valid;
    assign out_sum   = gStage[STAGES-1].r_sum;
    assign out_cout  = gStage[STAGES-1].r_carry;
    assign out_ovf   = gStage[STAGES-1].gTail.r_ovf;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Self-checking bench for cla_adder_pipe: directed corner cases, backpressure, mid-stream reset
// and a random stream scored against a plain-arithmetic reference queue.
module tb_cla_adder_pipe;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam int GROUP  = 4;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a      = '0;
    logic [WIDTH-1:0] in_b      = '0;
    logic             in_cin    = 1'b0;
`ifdef CLA_SUB_EN
    logic             in_sub    = 1'b0;
`endif
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] curA = '0;
    logic [WIDTH-1:0] curB = '0;
    logic             curCin = 1'b0;
    logic             curSub = 1'b0;
    bit               haveBeat = 1'b0;
    logic [WIDTH+1:0] expQ[$];
    logic [WIDTH+1:0] lastOut = '0;
    int accepted = 0;
    int received = 0;
    int stepCount = 0;
    int acceptStep = 0;
    int outStep = 0;

    cla_adder_pipe #(
        .WIDTH (WIDTH),
        .STAGES(STAGES),
        .GROUP (GROUP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
`ifdef CLA_SUB_EN
        .in_sub   (in_sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    // Reference result packed as {ovf, cout, sum}.
    function automatic logic [WIDTH+1:0] refAdd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic cin, input logic sub);
        logic [WIDTH-1:0] bEff;
        logic [WIDTH:0]   full;
        logic             ovf;
        bEff = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bEff} + {{WIDTH{1'b0}}, cin ^ sub};
        ovf  = (a[WIDTH-1] == bEff[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        return {ovf, full};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock: drive at the falling edge, observe handshakes 1ns later, transfer on the next rise.
    task automatic applyStimulus(input bit wantReady);
        @(negedge clk);
        in_valid  = haveBeat;
        in_a      = curA;
        in_b      = curB;
        in_cin    = curCin;
`ifdef CLA_SUB_EN
        in_sub    = curSub;
`endif
        out_ready = wantReady;
        #1;
        stepCount++;
        if (out_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("spuriousValid", {63'd0, out_valid}, 64'd0);
            end else begin
                checkOutput("sum", {32'd0, out_sum}, {32'd0, expQ[0][WIDTH-1:0]});
                checkOutput("cout", {63'd0, out_cout}, {63'd0, expQ[0][WIDTH]});
                checkOutput("ovf", {63'd0, out_ovf}, {63'd0, expQ[0][WIDTH+1]});
                if (out_ready) begin
                    lastOut = {out_ovf, out_cout, out_sum};
                    void'(expQ.pop_front());
                    received++;
                    outStep = stepCount;
                end
            end
        end
        if (in_valid && in_ready) begin
            expQ.push_back(refAdd(curA, curB, curCin, curSub));
            haveBeat = 1'b0;
            accepted++;
            acceptStep = stepCount;
        end
    endtask

    task automatic loadBeat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic cin, input logic sub);
        curA     = a;
        curB     = b;
        curCin   = cin;
`ifdef CLA_SUB_EN
        curSub   = sub;
`else
        curSub   = 1'b0 & sub;
`endif
        haveBeat = 1'b1;
    endtask

    task automatic runDirected(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin, input logic sub, input logic [WIDTH-1:0] expSum,
                               input logic expCout, input logic expOvf);
        int r0;
        r0 = received;
        loadBeat(a, b, cin, sub);
        for (int n = 0; n < 20 && received == r0; n++) applyStimulus(1'b1);
        checkOutput({tag, "_done"}, 64'(received - r0), 64'd1);
        checkOutput({tag, "_sum"}, {32'd0, lastOut[WIDTH-1:0]}, {32'd0, expSum});
        checkOutput({tag, "_cout"}, {63'd0, lastOut[WIDTH]}, {63'd0, expCout});
        checkOutput({tag, "_ovf"}, {63'd0, lastOut[WIDTH+1]}, {63'd0, expOvf});
        checkOutput({tag, "_latency"}, 64'(outStep - acceptStep), 64'(STAGES));
    endtask

    initial begin
        int a0;
        int r0;
        int idx;
        int sent;
        int budget;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("rstValid", {63'd0, out_valid}, 64'd0);
        checkOutput("rstSum", {32'd0, out_sum}, 64'd0);
        checkOutput("rstCout", {63'd0, out_cout}, 64'd0);
        checkOutput("rstOvf", {63'd0, out_ovf}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        runDirected("wrapAdd", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        runDirected("posOvf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        runDirected("negOvf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        runDirected("carryIn", 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
`ifdef CLA_SUB_EN
        runDirected("subNeg", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        runDirected("subPos", 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
`endif

        // Stalled output: the pipe holds exactly STAGES beats, then drains them in order.
        a0  = accepted;
        r0  = received;
        idx = 0;
        for (int n = 0; n < 8; n++) begin
            if (!haveBeat && idx < 8) begin
                loadBeat($urandom, $urandom, 1'(idx & 1), 1'b0);
                idx++;
            end
            applyStimulus(1'b0);
        end
        checkOutput("bpAccepted", 64'(accepted - a0), 64'(STAGES));
        checkOutput("bpInReady", {63'd0, in_ready}, 64'd0);
        budget = 0;
        while (received - r0 < 8 && budget < 100) begin
            if (!haveBeat && idx < 8) begin
                loadBeat($urandom, $urandom, 1'(idx & 1), 1'b0);
                idx++;
            end
            applyStimulus(1'b1);
            budget++;
        end
        checkOutput("bpReceived", 64'(received - r0), 64'd8);

        // Reset with beats in flight must drop them all.
        for (int n = 0; n < 3; n++) begin
            if (!haveBeat) loadBeat($urandom, $urandom, 1'b0, 1'b0);
            applyStimulus(1'b0);
        end
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        haveBeat = 1'b0;
        #1;
        checkOutput("rstMidValid", {63'd0, out_valid}, 64'd0);
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        r0 = received;
        for (int n = 0; n < 10; n++) applyStimulus(1'b1);
        checkOutput("rstNoStale", 64'(received - r0), 64'd0);

        // Random stream with random backpressure.
        a0     = accepted;
        r0     = received;
        sent   = 0;
        budget = 0;
        while ((sent < 3000 || haveBeat) && budget < 30000) begin
            if (!haveBeat && sent < 3000 && $urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 7))
                    0:       loadBeat(32'hFFFF_FFFF, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    1:       loadBeat(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    default: loadBeat($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                endcase
                sent++;
            end
            applyStimulus($urandom_range(0, 3) != 0);
            budget++;
        end
        budget = 0;
        while (expQ.size() != 0 && budget < 100) begin
            applyStimulus(1'b1);
            budget++;
        end
        checkOutput("rndAccepted", 64'(accepted - a0), 64'd3000);
        checkOutput("rndDrained", 64'(expQ.size()), 64'd0);
        checkOutput("rndCount", 64'(received - r0), 64'(accepted - a0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
